// File: rtl/cv32e40p_fpu_pkg.sv
// FPU shared encodings plus the NONCOMP constants: rm variants, CLASSIFY bits,
// fflags struct, per-format field widths and canonical NaNs.
package cv32e40p_fpu_pkg;

    localparam int unsigned OP_BITS        = 4;
    localparam int unsigned FP_FORMAT_BITS = 3;

    typedef enum logic [OP_BITS-1:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4,
        BF16    = 3'd5
    } fp_format_e;

    localparam logic [2:0] RM_SGNJ_J  = 3'd0;
    localparam logic [2:0] RM_SGNJ_JN = 3'd1;
    localparam logic [2:0] RM_SGNJ_JX = 3'd2;
    localparam logic [2:0] RM_MIN     = 3'd0;
    localparam logic [2:0] RM_MAX     = 3'd1;
    localparam logic [2:0] RM_CMP_LE  = 3'd0;
    localparam logic [2:0] RM_CMP_LT  = 3'd1;
    localparam logic [2:0] RM_CMP_EQ  = 3'd2;

    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fpu_status_t;

    localparam int unsigned FP32_EXP_W    = 8;
    localparam int unsigned FP32_MAN_W    = 23;
    localparam int unsigned FP16_EXP_W    = 5;
    localparam int unsigned FP16_MAN_W    = 10;
    localparam int unsigned FP16ALT_EXP_W = 8;
    localparam int unsigned FP16ALT_MAN_W = 7;

    localparam logic [31:0] CNAN_FP32    = 32'h7FC0_0000;
    localparam logic [15:0] CNAN_FP16    = 16'h7E00;
    localparam logic [15:0] CNAN_FP16ALT = 16'h7FC0;

endpackage

// File: rtl/cv32e40p_fpu_noncomp_slice.sv
// One-format NONCOMP datapath (SGNJ, MINMAX, CMP, CLASSIFY); purely combinational.
// Operands arrive already unboxed; illegal_o flags reserved rm or a non-NONCOMP op.
module cv32e40p_fpu_noncomp_slice
    import cv32e40p_fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  operation_e               op_i,
    input  logic [2:0]               rm_i,
    input  logic [EXP_W+MAN_W:0]     a_i,
    input  logic [EXP_W+MAN_W:0]     b_i,
    output logic [EXP_W+MAN_W:0]     fp_res_o,
    output logic [9:0]               int_res_o,
    output logic                     int_sel_o,
    output logic                     nv_o,
    output logic                     illegal_o
);

    localparam logic [EXP_W+MAN_W:0] CNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_nan, b_nan, a_snan, b_snan, a_inf, a_zero, b_zero, a_sub, a_norm;
    logic               any_nan, both_zero, a_lt_b, cmp_eq, cmp_lt;

    assign {sa, ea, ma} = a_i;
    assign {sb, eb, mb} = b_i;

    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_snan = a_nan && !ma[MAN_W-1];
    assign b_snan = b_nan && !mb[MAN_W-1];
    assign a_inf  = (&ea) && !(|ma);
    assign a_zero = !(|ea) && !(|ma);
    assign b_zero = !(|eb) && !(|mb);
    assign a_sub  = !(|ea) && (|ma);
    assign a_norm = (|ea) && !(&ea);

    assign any_nan   = a_nan || b_nan;
    assign both_zero = a_zero && b_zero;

    // Total order on non-NaN values where -0 sits below +0; CMP masks out the zero pair.
    assign a_lt_b = (sa != sb) ? sa
                  : (sa ? (a_i[EXP_W+MAN_W-1:0] > b_i[EXP_W+MAN_W-1:0])
                        : (a_i[EXP_W+MAN_W-1:0] < b_i[EXP_W+MAN_W-1:0]));
    assign cmp_eq = (a_i == b_i) || both_zero;
    assign cmp_lt = a_lt_b && !both_zero;

    always_comb begin
        fp_res_o  = '0;
        int_res_o = '0;
        int_sel_o = 1'b0;
        nv_o      = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            SGNJ: begin
                case (rm_i)
                    RM_SGNJ_J:  fp_res_o = {sb,      a_i[EXP_W+MAN_W-1:0]};
                    RM_SGNJ_JN: fp_res_o = {!sb,     a_i[EXP_W+MAN_W-1:0]};
                    RM_SGNJ_JX: fp_res_o = {sa ^ sb, a_i[EXP_W+MAN_W-1:0]};
                    default:    illegal_o = 1'b1;
                endcase
            end
            MINMAX: begin
                if (rm_i == RM_MIN || rm_i == RM_MAX) begin
                    nv_o = a_snan || b_snan;
                    if (a_nan && b_nan)                fp_res_o = CNAN;
                    else if (a_nan)                    fp_res_o = b_i;
                    else if (b_nan)                    fp_res_o = a_i;
                    else if ((rm_i == RM_MIN) == a_lt_b) fp_res_o = a_i;
                    else                               fp_res_o = b_i;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            CMP: begin
                int_sel_o = 1'b1;
                case (rm_i)
                    RM_CMP_LE: begin
                        int_res_o[0] = !any_nan && (cmp_lt || cmp_eq);
                        nv_o         = any_nan;
                    end
                    RM_CMP_LT: begin
                        int_res_o[0] = !any_nan && cmp_lt;
                        nv_o         = any_nan;
                    end
                    RM_CMP_EQ: begin
                        int_res_o[0] = !any_nan && cmp_eq;
                        nv_o         = a_snan || b_snan;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            CLASSIFY: begin
                int_sel_o                = 1'b1;
                int_res_o[CLS_NEG_INF]   = sa && a_inf;
                int_res_o[CLS_NEG_NORM]  = sa && a_norm;
                int_res_o[CLS_NEG_SUB]   = sa && a_sub;
                int_res_o[CLS_NEG_ZERO]  = sa && a_zero;
                int_res_o[CLS_POS_ZERO]  = !sa && a_zero;
                int_res_o[CLS_POS_SUB]   = !sa && a_sub;
                int_res_o[CLS_POS_NORM]  = !sa && a_norm;
                int_res_o[CLS_POS_INF]   = !sa && a_inf;
                int_res_o[CLS_SNAN]      = a_snan;
                int_res_o[CLS_QNAN]      = a_nan && !a_snan;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cv32e40p_fpu_noncomp_pipe.sv
// NONCOMP execution unit: per-format slices, fmt mux, then NUM_PIPE_REGS stages
// with valid/ready backpressure. `CV32E40P_FPU_NONCOMP_SMALLFMT_EN adds FP16/FP16ALT/BF16.
module cv32e40p_fpu_noncomp_pipe
    import cv32e40p_fpu_pkg::*;
#(
    parameter int unsigned FLEN          = 32,
    parameter int unsigned NUM_PIPE_REGS = 1,
    parameter int unsigned TAG_WIDTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [OP_BITS-1:0]        op_i,
    input  logic [2:0]                rm_i,
    input  logic [FP_FORMAT_BITS-1:0] fmt_i,
    input  logic [FLEN-1:0]           operand_a_i,
    input  logic [FLEN-1:0]           operand_b_i,
    input  logic [TAG_WIDTH-1:0]      tag_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [FLEN-1:0]           result_o,
    output logic [4:0]                status_o,
    output logic [TAG_WIDTH-1:0]      tag_o,
    output logic                      busy_o
);

    operation_e     op;
    logic [31:0]    a32, b32, s32_fp;
    logic [9:0]     s32_int;
    logic           s32_is, s32_nv, s32_ill;
    logic [FLEN-1:0] res_d;
    fpu_status_t    st_d;

    assign op = operation_e'(op_i);

    if (FLEN > 32) begin : g_box32
        assign a32 = (&operand_a_i[FLEN-1:32]) ? operand_a_i[31:0] : CNAN_FP32;
        assign b32 = (&operand_b_i[FLEN-1:32]) ? operand_b_i[31:0] : CNAN_FP32;
    end else begin : g_nobox32
        assign a32 = operand_a_i[31:0];
        assign b32 = operand_b_i[31:0];
    end

    cv32e40p_fpu_noncomp_slice #(.EXP_W(FP32_EXP_W), .MAN_W(FP32_MAN_W)) u_fp32 (
        .op_i(op), .rm_i(rm_i), .a_i(a32), .b_i(b32),
        .fp_res_o(s32_fp), .int_res_o(s32_int), .int_sel_o(s32_is),
        .nv_o(s32_nv), .illegal_o(s32_ill)
    );

`ifdef CV32E40P_FPU_NONCOMP_SMALLFMT_EN
    logic [15:0] a16, b16, ah, bh, s16_fp, sh_fp;
    logic [9:0]  s16_int, sh_int;
    logic        s16_is, s16_nv, s16_ill, sh_is, sh_nv, sh_ill;

    // Improperly boxed narrow operands read as that format's canonical NaN.
    assign a16 = (&operand_a_i[FLEN-1:16]) ? operand_a_i[15:0] : CNAN_FP16;
    assign b16 = (&operand_b_i[FLEN-1:16]) ? operand_b_i[15:0] : CNAN_FP16;
    assign ah  = (&operand_a_i[FLEN-1:16]) ? operand_a_i[15:0] : CNAN_FP16ALT;
    assign bh  = (&operand_b_i[FLEN-1:16]) ? operand_b_i[15:0] : CNAN_FP16ALT;

    cv32e40p_fpu_noncomp_slice #(.EXP_W(FP16_EXP_W), .MAN_W(FP16_MAN_W)) u_fp16 (
        .op_i(op), .rm_i(rm_i), .a_i(a16), .b_i(b16),
        .fp_res_o(s16_fp), .int_res_o(s16_int), .int_sel_o(s16_is),
        .nv_o(s16_nv), .illegal_o(s16_ill)
    );

    cv32e40p_fpu_noncomp_slice #(.EXP_W(FP16ALT_EXP_W), .MAN_W(FP16ALT_MAN_W)) u_fp16alt (
        .op_i(op), .rm_i(rm_i), .a_i(ah), .b_i(bh),
        .fp_res_o(sh_fp), .int_res_o(sh_int), .int_sel_o(sh_is),
        .nv_o(sh_nv), .illegal_o(sh_ill)
    );
`endif

    always_comb begin
        logic            legal, int_sel, nv;
        logic [FLEN-1:0] fp_res;
        logic [9:0]      int_res;
        legal   = 1'b0;
        int_sel = 1'b0;
        nv      = 1'b0;
        fp_res  = '1;
        int_res = '0;
        case (fmt_i)
            FP32: begin
                legal        = !s32_ill;
                fp_res[31:0] = s32_fp;
                int_res      = s32_int;
                int_sel      = s32_is;
                nv           = s32_nv;
            end
`ifdef CV32E40P_FPU_NONCOMP_SMALLFMT_EN
            FP16: begin
                legal        = !s16_ill;
                fp_res[15:0] = s16_fp;
                int_res      = s16_int;
                int_sel      = s16_is;
                nv           = s16_nv;
            end
            FP16ALT, BF16: begin
                legal        = !sh_ill;
                fp_res[15:0] = sh_fp;
                int_res      = sh_int;
                int_sel      = sh_is;
                nv           = sh_nv;
            end
`endif
            default: legal = 1'b0;
        endcase
        res_d = '0;
        st_d  = '0;
        if (!legal) begin
            st_d.nv = 1'b1;
        end else begin
            st_d.nv = nv;
            if (int_sel) res_d[9:0] = int_res;
            else         res_d      = fp_res;
        end
    end

    if (NUM_PIPE_REGS == 0) begin : g_comb
        assign in_ready_o  = out_ready_i && !flush_i;
        assign out_valid_o = in_valid_i && !flush_i;
        assign result_o    = res_d;
        assign status_o    = st_d;
        assign tag_o       = tag_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        localparam int N = int'(NUM_PIPE_REGS);

        logic [N-1:0]                vld_pipe, rdy;
        logic [N-1:0][FLEN-1:0]      res_q;
        logic [N-1:0][4:0]           st_q;
        logic [N-1:0][TAG_WIDTH-1:0] tag_q;

        // A stage can take new data if it is empty or everything after it drains this cycle.
        always_comb begin
            logic r;
            rdy = '0;
            r   = out_ready_i;
            for (int k = N - 1; k >= 0; k--) begin
                r      = !vld_pipe[k] || r;
                rdy[k] = r;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_pipe <= '0;
                res_q    <= '0;
                st_q     <= '0;
                tag_q    <= '0;
            end else if (flush_i) begin
                vld_pipe <= '0;
            end else begin
                if (rdy[0]) begin
                    vld_pipe[0] <= in_valid_i;
                    res_q[0]    <= res_d;
                    st_q[0]     <= st_d;
                    tag_q[0]    <= tag_i;
                end
                for (int k = 1; k < N; k++) begin
                    if (rdy[k]) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        res_q[k]    <= res_q[k-1];
                        st_q[k]     <= st_q[k-1];
                        tag_q[k]    <= tag_q[k-1];
                    end
                end
            end
        end

        assign in_ready_o  = !flush_i && rdy[0];
        assign out_valid_o = vld_pipe[N-1];
        assign result_o    = res_q[N-1];
        assign status_o    = st_q[N-1];
        assign tag_o       = tag_q[N-1];
        assign busy_o      = |vld_pipe;
    end

endmodule
